mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified byte-addressed memory between the instruction-fetch (IF) and
//  load/store (LS) requesters of the multi-cycle CPU. Arbitrates per access with round-robin,
//  drives the memory strobes for a fixed hold time, and captures read data. Accesses are
//  checked for word alignment and range; an error access returns ack+err with no strobes.
// PARAMETERS
//  WAIT_CYCLES  1   extra cycles the memory strobes are held beyond the first (>=1)
//  ADDR_BITS    10  memory byte-address width (1024 bytes)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  if_req     in   1       IF read request; held with if_addr until if_ack
//  if_addr    in   `WIDTH  IF byte address
//  if_ack     out  1       one-cycle completion pulse for IF
//  if_rdata   out  `WIDTH  IF read data, valid from if_ack, held until next IF completion
//  if_err     out  1       with if_ack: misaligned or out-of-range
//  ls_req     in   1       LS request; ls_we, ls_addr, ls_wdata held until ls_ack
//  ls_we      in   1       1 = word write, 0 = word read
//  ls_addr    in   `WIDTH  LS byte address
//  ls_wdata   in   `WIDTH  LS write data
//  ls_ack     out  1       one-cycle completion pulse for LS
//  ls_rdata   out  `WIDTH  LS read data, valid from ls_ack, held until next LS read
//  ls_err     out  1       with ls_ack: misaligned or out-of-range
//  mem_rd     out  1       memory MemRd strobe
//  mem_wr     out  1       memory MemWr strobe
//  mem_addr   out  `WIDTH  memory address
//  mem_wdata  out  `WIDTH  memory W_data
//  mem_rdata  in   `WIDTH  memory R_data
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, all strobes/acks/errs 0, mem_addr/mem_wdata 0,
//    if_rdata/ls_rdata 0, last_grant = LS (so IF wins first contention). Reset mid-access
//    drops mem_rd/mem_wr at once; the access is abandoned, no ack.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE; error path IDLE -> DONE.
//  - IDLE: sample reqs. One req -> grant it. Both -> grant the port not in last_grant.
//    Register grant, last_grant, mem_addr, mem_wdata, we. Legal: go ACCESS, cnt=WAIT_CYCLES.
//    Illegal (addr[1:0]!=0 or addr > 2**ADDR_BITS-4): go DONE with err flag set.
//  - ACCESS: mem_rd=!we or mem_wr=we held stable for WAIT_CYCLES+1 cycles, address/data
//    constant throughout (memory write is level/delay based). cnt decrements; at cnt==0 on a
//    read, mem_rdata latched into granted port's rdata; go DONE.
//  - DONE: strobes 0; granted port's ack=1 for exactly one cycle, err=flag; -> IDLE.
//  - Latency: req sampled in IDLE at edge N -> ack high in cycle N+WAIT_CYCLES+2; error ack
//    in cycle N+1. Back-to-back: req held after ack is re-arbitrated in the next IDLE.
//  - Write never modifies either rdata; err access never modifies rdata or memory.
//  - Req dropped before ack is a protocol violation; access still completes and acks.
//  - Only one ack high in any cycle; mem_rd and mem_wr never high together.
//  - Range check uses full 32-bit address; upper bits nonzero => error.
// STRUCTURE
//  - header.h: `WIDTH, state encodings (ST_IDLE, ST_ACCESS, ST_DONE), port ids (GNT_IF,
//    GNT_LS).
//  - Sub-module rr_pick2: combinational 2-way round-robin (req_a, req_b, last -> gnt).
//  - Top holds FSM, wait counter (width $clog2(WAIT_CYCLES+1)), capture registers.
// TESTING
//  - IF only, addr 0x10, mem word 0x014B4820 -> mem_rd 2 cycles, if_ack cycle 3, rdata match.
//  - Both req same cycle after reset -> IF served first, LS next; repeat -> strict alternation.
//  - LS write 0xDEADBEEF @0x20, then LS read @0x20 -> ls_rdata 0xDEADBEEF, if_rdata unchanged.
//  - LS read @0x22 and @0x3FE and @0x400 -> ls_ack+ls_err next cycle, no strobes.
//  - Assert rst_n low mid-ACCESS -> strobes drop same time, no ack, IF wins next contention.
//  - WAIT_CYCLES=3 build: strobes held 4 cycles, address stable, ack at N+5.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the IF/LS unified-memory port arbiter.
// Holds the data width, the FSM state encoding, the port ids and the address check.
package mem_port_arbiter_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_t;

  // Word aligned and inside the memory; the full 32-bit address takes part in the compare.
  function automatic logic addr_ok(input logic [WIDTH-1:0] addr, input int unsigned addr_bits);
    logic [WIDTH-1:0] w_limit;
    w_limit = (32'd1 << addr_bits) - 32'd4;
    return (addr[1:0] == 2'b00) && (addr <= w_limit);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on contention the port not granted last wins.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic valid,
  output logic gnt
);

  // Pick a winner among the live requests.
  always_comb begin
    valid = req_a | req_b;
    gnt   = GNT_IF;
    if (req_a && req_b) begin
      gnt = (last == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (req_b) begin
      gnt = GNT_LS;
    end else begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and LS requesters onto one byte-addressed memory, holds the
// strobes for WAIT_CYCLES+1 cycles, captures read data and flags illegal addresses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BITS   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ack,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_ack,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_err,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_gnt, w_gnt_nxt;
  logic             r_last, w_last_nxt;
  logic             r_we, w_we_nxt;
  logic             r_rd, w_rd_nxt;
  logic             r_wr, w_wr_nxt;
  logic [WIDTH-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic             r_if_ack, w_if_ack_nxt;
  logic             r_ls_ack, w_ls_ack_nxt;
  logic             r_if_err, w_if_err_nxt;
  logic             r_ls_err, w_ls_err_nxt;
  logic [WIDTH-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [WIDTH-1:0] r_ls_rdata, w_ls_rdata_nxt;

  logic             w_pick_valid;
  logic             w_pick;
  logic [WIDTH-1:0] w_sel_addr;
  logic             w_sel_we;

  rr_pick2 u_pick (
    .req_a (if_req),
    .req_b (ls_req),
    .last  (r_last),
    .valid (w_pick_valid),
    .gnt   (w_pick)
  );

  // Request of the winning port, used only while IDLE.
  always_comb begin
    w_sel_addr = if_addr;
    w_sel_we   = 1'b0;
    if (w_pick == GNT_LS) begin
      w_sel_addr = ls_addr;
      w_sel_we   = ls_we;
    end else begin
      w_sel_addr = if_addr;
      w_sel_we   = 1'b0;
    end
  end

  // Next-state and next-output logic; acks and errs default low so each pulses one cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_gnt_nxt      = r_gnt;
    w_last_nxt     = r_last;
    w_we_nxt       = r_we;
    w_rd_nxt       = r_rd;
    w_wr_nxt       = r_wr;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_if_rdata_nxt = r_if_rdata;
    w_ls_rdata_nxt = r_ls_rdata;
    w_if_ack_nxt   = 1'b0;
    w_ls_ack_nxt   = 1'b0;
    w_if_err_nxt   = 1'b0;
    w_ls_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt  = w_pick;
          w_last_nxt = w_pick;
          w_addr_nxt = w_sel_addr;
          w_we_nxt   = w_sel_we;
          if (w_pick == GNT_LS) begin
            w_wdata_nxt = ls_wdata;
          end else begin
            w_wdata_nxt = r_wdata;
          end
          if (addr_ok(w_sel_addr, ADDR_BITS)) begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = CNT_INIT;
            w_rd_nxt    = ~w_sel_we;
            w_wr_nxt    = w_sel_we;
          end else begin
            // Illegal address: no strobes, acknowledge with error straight away.
            w_state_nxt  = ST_DONE;
            w_rd_nxt     = 1'b0;
            w_wr_nxt     = 1'b0;
            w_if_ack_nxt = (w_pick == GNT_IF);
            w_if_err_nxt = (w_pick == GNT_IF);
            w_ls_ack_nxt = (w_pick == GNT_LS);
            w_ls_err_nxt = (w_pick == GNT_LS);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt  = ST_DONE;
          w_rd_nxt     = 1'b0;
          w_wr_nxt     = 1'b0;
          w_if_ack_nxt = (r_gnt == GNT_IF);
          w_ls_ack_nxt = (r_gnt == GNT_LS);
          if (!r_we && (r_gnt == GNT_IF)) begin
            w_if_rdata_nxt = mem_rdata;
          end else if (!r_we) begin
            w_ls_rdata_nxt = mem_rdata;
          end else begin
            w_ls_rdata_nxt = r_ls_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; reset drops the strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_gnt      <= GNT_IF;
      r_last     <= GNT_LS;
      r_we       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_ls_err   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_last     <= w_last_nxt;
      r_we       <= w_we_nxt;
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_if_ack   <= w_if_ack_nxt;
      r_ls_ack   <= w_ls_ack_nxt;
      r_if_err   <= w_if_err_nxt;
      r_ls_err   <= w_ls_err_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_ls_rdata <= w_ls_rdata_nxt;
    end
  end

  assign if_ack    = r_if_ack;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign ls_ack    = r_ls_ack;
  assign ls_err    = r_ls_err;
  assign ls_rdata  = r_ls_rdata;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized rounds
// checked against a transaction-level model of grant order, latency and memory contents.
module tb_mem_port_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_ack, if_err, ls_ack, ls_err, mem_rd, mem_wr;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dev_mem [0:255];
  logic [31:0] ref_mem [0:255];
  bit          model_last_ls;
  logic [31:0] exp_if_rdata, exp_ls_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Simple memory device: combinational read, write while the write strobe is high.
  assign mem_rdata = dev_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wr) dev_mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic int lat(input bit ok);
    return ok ? W + 2 : 1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 255)) << 2;
    if (k == 7) a = a | 32'($urandom_range(1, 3));
    if (k == 8) a = a + 32'h400;
    if (k == 9) a = $urandom | 32'h8000_0000;
    return a;
  endfunction

  // One round: raise the chosen requests in an IDLE cycle and check every cycle until both
  // are acknowledged, plus one idle cycle afterwards. Starts and ends on a falling edge.
  task automatic run_round(input bit di, input logic [31:0] ia, input bit dl,
                           input bit lwe, input logic [31:0] la, input logic [31:0] lwd);
    bit ok_if, ok_ls, ls_first, have, exp_rd, exp_wr;
    int s_if, s_ls, t_if, t_ls, tmax;
    logic [31:0] exp_a;
    ok_if    = legal(ia);
    ok_ls    = legal(la);
    ls_first = dl && (!di || !model_last_ls);
    if (ls_first) begin
      s_ls = 0; t_ls = lat(ok_ls); s_if = t_ls + 1; t_if = s_if + lat(ok_if);
    end else begin
      s_if = 0; t_if = lat(ok_if); s_ls = t_if + 1; t_ls = s_ls + lat(ok_ls);
    end
    if (!di) t_if = -1;
    if (!dl) t_ls = -1;
    tmax = (t_if > t_ls) ? t_if : t_ls;
    if (di && dl) model_last_ls = !ls_first;
    else if (dl)  model_last_ls = 1'b1;
    else if (di)  model_last_ls = 1'b0;

    if_req = di; if_addr = ia;
    ls_req = dl; ls_we = lwe; ls_addr = la; ls_wdata = lwd;
    for (int t = 1; t <= tmax + 1; t++) begin
      @(negedge clk);
      have = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_a = 32'd0;
      if (di && ok_if && t >= s_if + 1 && t <= s_if + W + 1) begin
        have = 1'b1; exp_rd = 1'b1; exp_a = ia;
      end
      if (dl && ok_ls && t >= s_ls + 1 && t <= s_ls + W + 1) begin
        have = 1'b1; exp_rd = !lwe; exp_wr = lwe; exp_a = la;
      end
      check_eq("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd});
      check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
      if (have) check_eq("mem_addr", mem_addr, exp_a);
      if (exp_wr) check_eq("mem_wdata", mem_wdata, lwd);
      check_eq("if_ack", {31'd0, if_ack}, {31'd0, t == t_if});
      check_eq("ls_ack", {31'd0, ls_ack}, {31'd0, t == t_ls});
      if (t == t_if) begin
        if (ok_if) exp_if_rdata = ref_mem[ia[9:2]];
        check_eq("if_err", {31'd0, if_err}, {31'd0, !ok_if});
        check_eq("if_rdata", if_rdata, exp_if_rdata);
        check_eq("ls_rdata@if", ls_rdata, exp_ls_rdata);
        if_req = 1'b0;
      end
      if (t == t_ls) begin
        if (ok_ls && lwe)  ref_mem[la[9:2]] = lwd;
        if (ok_ls && !lwe) exp_ls_rdata = ref_mem[la[9:2]];
        check_eq("ls_err", {31'd0, ls_err}, {31'd0, !ok_ls});
        check_eq("ls_rdata", ls_rdata, exp_ls_rdata);
        check_eq("if_rdata@ls", if_rdata, exp_if_rdata);
        ls_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[4] = 32'h014B4820;
    ref_mem[4] = 32'h014B4820;
    model_last_ls = 1'b1;
    exp_if_rdata  = 32'd0;
    exp_ls_rdata  = 32'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    check_eq("rst_errs", {30'd0, if_err, ls_err}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_ls_rdata", ls_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_round(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("if_word_0x10", if_rdata, 32'h014B4820);
    for (int i = 0; i < 4; i++)
      run_round(1'b1, 32'h100 + 32'(i * 8), 1'b1, 1'b0, 32'h200 + 32'(i * 8), 32'd0);
    run_round(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    run_round(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
    check_eq("ls_readback", ls_rdata, 32'hDEADBEEF);
    run_round(1'b0, 32'd0, 1'b1, 1'b0, 32'h22, 32'd0);
    run_round(1'b0, 32'd0, 1'b1, 1'b0, 32'h3FE, 32'd0);
    run_round(1'b0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0);
    run_round(1'b1, 32'h8000_0010, 1'b1, 1'b1, 32'h3FC, 32'h1234_5678);

    // Reset in the middle of an access: strobe drops at once, no ack, IF wins afterwards.
    if_req = 1'b1; if_addr = 32'h40;
    @(posedge clk);
    #1 check_eq("pre_rst_rd", {31'd0, mem_rd}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_drop_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_drop_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_no_ack", {30'd0, if_ack, ls_ack}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last_ls = 1'b1;
    exp_if_rdata  = 32'd0;
    exp_ls_rdata  = 32'd0;
    check_eq("post_rst_if_rdata", if_rdata, 32'd0);
    check_eq("post_rst_ls_rdata", ls_rdata, 32'd0);
    run_round(1'b1, 32'h44, 1'b1, 1'b0, 32'h48, 32'd0);

    for (int r = 0; r < 300; r++) begin
      bit          di, dl, lwe;
      int          pick;
      logic [31:0] ia, la, lwd;
      pick = $urandom_range(0, 2);
      di   = (pick != 1);
      dl   = (pick != 0);
      lwe  = $urandom_range(0, 1) == 1;
      ia   = rand_addr();
      la   = rand_addr();
      lwd  = $urandom;
      run_round(di, ia, dl, lwe, la, lwd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
